// File: rtl/cnt_checker_pkg.sv
// Shared types for the counter stream checker: FSM states, mismatch event record
// and the expected-next-value helper.
package cnt_checker_pkg;

   localparam int EV_W = 8;

   typedef enum logic [1:0] {
      IDLE,
      SYNC,
      TRACK
   } chk_state_e;

   typedef struct packed {
      logic [EV_W-1:0] exp;
      logic [EV_W-1:0] got;
   } cnt_ev_t;

   localparam logic [EV_W-1:0] EV_ONE = 1;

   function automatic logic [EV_W-1:0] next_exp(input logic [EV_W-1:0] prev,
                                                input logic            inc_dec);
      return inc_dec ? (prev + EV_ONE) : (prev - EV_ONE);
   endfunction

endpackage

// File: rtl/cnt_checker_if.sv
// Mismatch event port: the checker presents {exp, got} with valid, the consumer
// drains at its own pace with ready.
interface cnt_checker_if #(parameter int W = 8);

   logic         ev_valid;
   logic         ev_ready;
   logic [W-1:0] ev_exp;
   logic [W-1:0] ev_got;

   modport master (output ev_valid, output ev_exp, output ev_got, input ev_ready);
   modport slave  (input ev_valid, input ev_exp, input ev_got, output ev_ready);

endinterface

// File: rtl/cnt_ev_fifo.sv
// Small synchronous FIFO of mismatch events with flush; push while full is only
// accepted when a pop frees a slot in the same cycle.
module cnt_ev_fifo
   import cnt_checker_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic    clk,
   input  logic    rst_n,
   input  logic    push_i,
   input  cnt_ev_t data_i,
   input  logic    pop_i,
   input  logic    flush_i,
   output cnt_ev_t data_o,
   output logic    full_o,
   output logic    empty_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = 1;

   cnt_ev_t     mem_q [DEPTH];
   logic [AW:0] wrPtr_q;
   logic [AW:0] rdPtr_q;
   logic        doPush;
   logic        doPop;

   // Pointers carry one extra bit so full and empty are distinguishable.
   assign empty_o = (wrPtr_q == rdPtr_q);
   assign full_o  = (wrPtr_q[AW] != rdPtr_q[AW]) &&
                    (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
   assign doPop   = pop_i && !empty_o;
   assign doPush  = push_i && (!full_o || doPop);
   assign data_o  = mem_q[rdPtr_q[AW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (flush_i) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
      end else begin
         if (doPush) begin
            mem_q[wrPtr_q[AW-1:0]] <= data_i;
            wrPtr_q                <= wrPtr_q + PTR_ONE;
         end
         if (doPop) begin
            rdPtr_q <= rdPtr_q + PTR_ONE;
         end
      end
   end

endmodule

// File: rtl/cnt_checker.sv
// Checks that a counter stream steps by exactly one each clock, keeps saturating
// error/wrap statistics and queues every mismatch as an {expected, got} event.
module cnt_checker
   import cnt_checker_pkg::*;
#(
   parameter int W      = 8,
   parameter int STAT_W = 16,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              inc_dec_i,
   input  logic [W-1:0]      cnt_i,
   input  logic              en_i,
   input  logic              clr_i,
   output logic              locked_o,
   output logic              err_o,
   output logic [STAT_W-1:0] err_cnt_o,
   output logic [STAT_W-1:0] wrap_cnt_o,
   output logic              ev_ovf_o,
   cnt_checker_if.master     ev_if
);

   localparam logic [STAT_W-1:0] STAT_ONE = 1;

   chk_state_e        state_q, state_d;
   logic [W-1:0]      prev_q, prev_d;
   logic              locked_q, locked_d;
   logic              err_q, err_d;
   logic [STAT_W-1:0] errCnt_q, errCnt_d;
   logic [STAT_W-1:0] wrapCnt_q, wrapCnt_d;
   logic              ovf_q, ovf_d;

   logic [W-1:0]      expVal;
   logic              match;
   logic              wrapPoint;
   logic              push;
   logic              pop;
   logic              fifoFull;
   logic              fifoEmpty;
   cnt_ev_t           evIn;
   cnt_ev_t           evHead;

   assign expVal    = next_exp(prev_q, inc_dec_i);
   assign match     = (cnt_i == expVal);
   assign wrapPoint = inc_dec_i ? (prev_q == '1) : (prev_q == '0);
   assign pop       = ev_if.ev_valid && ev_if.ev_ready;
   assign evIn      = '{exp: expVal, got: cnt_i};

   always_comb begin
      state_d   = state_q;
      prev_d    = prev_q;
      err_d     = err_q;
      errCnt_d  = errCnt_q;
      wrapCnt_d = wrapCnt_q;
      ovf_d     = ovf_q;
      push      = 1'b0;

      if (!en_i) begin
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE: state_d = SYNC;
            SYNC: begin
               prev_d  = cnt_i;
               state_d = TRACK;
            end
            TRACK: begin
               // Always resync to the observed value so one jump costs one error.
               prev_d = cnt_i;
               if (!match) begin
                  err_d = 1'b1;
                  push  = 1'b1;
                  if (errCnt_q != '1) errCnt_d = errCnt_q + STAT_ONE;
                  if (fifoFull && !pop) ovf_d = 1'b1;
               end else if (wrapPoint) begin
                  if (wrapCnt_q != '1) wrapCnt_d = wrapCnt_q + STAT_ONE;
               end
            end
            default: state_d = IDLE;
         endcase
      end

      locked_d = (state_d == TRACK);

      if (clr_i) begin
         err_d     = 1'b0;
         errCnt_d  = '0;
         wrapCnt_d = '0;
         ovf_d     = 1'b0;
         push      = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         prev_q    <= '0;
         locked_q  <= 1'b0;
         err_q     <= 1'b0;
         errCnt_q  <= '0;
         wrapCnt_q <= '0;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         prev_q    <= prev_d;
         locked_q  <= locked_d;
         err_q     <= err_d;
         errCnt_q  <= errCnt_d;
         wrapCnt_q <= wrapCnt_d;
         ovf_q     <= ovf_d;
      end
   end

   cnt_ev_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push),
      .data_i  (evIn),
      .pop_i   (pop),
      .flush_i (clr_i),
      .data_o  (evHead),
      .full_o  (fifoFull),
      .empty_o (fifoEmpty)
   );

   assign locked_o       = locked_q;
   assign err_o          = err_q;
   assign err_cnt_o      = errCnt_q;
   assign wrap_cnt_o     = wrapCnt_q;
   assign ev_ovf_o       = ovf_q;
   assign ev_if.ev_valid = !fifoEmpty;
   assign ev_if.ev_exp   = evHead.exp;
   assign ev_if.ev_got   = evHead.got;

endmodule

// File: tb/tb_cnt_checker.sv
// Randomised scoreboard bench for cnt_checker: a value-level reference model
// predicts statistics and queues expected events; a monitor drains and compares them.
module tb_cnt_checker;

   localparam int DEPTH = 4;

   logic        clk;
   logic        rst_n;
   logic        incDec;
   logic [7:0]  cnt;
   logic        en;
   logic        clr;
   logic        locked;
   logic        err;
   logic [15:0] errCnt;
   logic [15:0] wrapCnt;
   logic        evOvf;

   cnt_checker_if #(.W(8)) evIf ();

   cnt_checker #(.W(8), .STAT_W(16), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .inc_dec_i  (incDec),
      .cnt_i      (cnt),
      .en_i       (en),
      .clr_i      (clr),
      .locked_o   (locked),
      .err_o      (err),
      .err_cnt_o  (errCnt),
      .wrap_cnt_o (wrapCnt),
      .ev_ovf_o   (evOvf),
      .ev_if      (evIf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int e;
      int g;
   } evRec_t;

   evRec_t sbq[$];
   int nCompared   = 0;
   int nMismatched = 0;

   // Reference model: value-level view of the checker.
   int runLen;
   int mPrev;
   int mLocked;
   int mErr;
   int mErrCnt;
   int mWrapCnt;
   int mOvf;
   int mOcc;

   task automatic checkOutput(input string name, input int act, input int expv);
      nCompared++;
      if (act != expv) begin
         nMismatched++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, expv, $time);
      end
   endtask

   task automatic modelReset();
      runLen   = 0;
      mPrev    = 0;
      mLocked  = 0;
      mErr     = 0;
      mErrCnt  = 0;
      mWrapCnt = 0;
      mOvf     = 0;
      mOcc     = 0;
      sbq.delete();
   endtask

   task automatic modelEdge(input int c, input bit e, input bit inc, input bit cl, input bit rdy);
      bit     popping;
      bit     mismatch;
      int     expv;
      int     occBefore;
      evRec_t rec;
      popping   = rdy && (mOcc > 0);
      mismatch  = 1'b0;
      occBefore = mOcc;
      expv      = 0;
      if (!e) begin
         runLen = 0;
      end else begin
         if (runLen == 1) begin
            mPrev = c;
         end else if (runLen >= 2) begin
            expv = inc ? (mPrev + 1) % 256 : (mPrev + 255) % 256;
            if (c == expv) begin
               if (expv == (inc ? 0 : 255) && mWrapCnt < 65535) mWrapCnt++;
            end else begin
               mismatch = 1'b1;
            end
            mPrev = c;
         end
         if (runLen < 2) runLen++;
      end
      mLocked = (e && runLen >= 2) ? 1 : 0;
      if (cl) begin
         mErr     = 0;
         mErrCnt  = 0;
         mWrapCnt = 0;
         mOvf     = 0;
         mOcc     = 0;
         while (sbq.size() > (popping ? 1 : 0)) void'(sbq.pop_back());
      end else begin
         if (mismatch) begin
            mErr = 1;
            if (mErrCnt < 65535) mErrCnt++;
            if (occBefore < DEPTH || popping) begin
               rec.e = expv;
               rec.g = c;
               sbq.push_back(rec);
               mOcc++;
            end else begin
               mOvf = 1;
            end
         end
         if (popping) mOcc--;
      end
   endtask

   task automatic checkAll();
      checkOutput("locked", int'(locked), mLocked);
      checkOutput("err", int'(err), mErr);
      checkOutput("err_cnt", int'(errCnt), mErrCnt);
      checkOutput("wrap_cnt", int'(wrapCnt), mWrapCnt);
      checkOutput("ev_valid", int'(evIf.ev_valid), (mOcc > 0) ? 1 : 0);
      checkOutput("ev_ovf", int'(evOvf), mOvf);
   endtask

   // Drives one cycle of inputs, advances the model, then samples after the edge.
   task automatic applyStimulus(input int c, input bit e, input bit inc, input bit cl, input bit rdy);
      cnt          = 8'(c);
      en           = e;
      incDec       = inc;
      clr          = cl;
      evIf.ev_ready = rdy;
      modelEdge(c, e, inc, cl, rdy);
      @(posedge clk);
      #2;
      checkAll();
   endtask

   task automatic checkAllZero();
      checkOutput("rst_locked", int'(locked), 0);
      checkOutput("rst_err", int'(err), 0);
      checkOutput("rst_err_cnt", int'(errCnt), 0);
      checkOutput("rst_wrap_cnt", int'(wrapCnt), 0);
      checkOutput("rst_ev_valid", int'(evIf.ev_valid), 0);
      checkOutput("rst_ev_exp", int'(evIf.ev_exp), 0);
      checkOutput("rst_ev_got", int'(evIf.ev_got), 0);
      checkOutput("rst_ev_ovf", int'(evOvf), 0);
   endtask

   // Monitor: every accepted handshake must match the oldest predicted event.
   always @(negedge clk) begin
      evRec_t rec;
      if (rst_n === 1'b1 && evIf.ev_valid === 1'b1 && evIf.ev_ready === 1'b1) begin
         if (sbq.size() == 0) begin
            checkOutput("ev_unexpected", 1, 0);
         end else begin
            rec = sbq.pop_front();
            checkOutput("ev_exp", int'(evIf.ev_exp), rec.e);
            checkOutput("ev_got", int'(evIf.ev_got), rec.g);
         end
      end
   end

   initial begin
      int  v;
      bit  inc;
      bit  e;
      int  r;
      rst_n         = 1'b1;
      en            = 1'b0;
      clr           = 1'b0;
      incDec        = 1'b1;
      cnt           = 8'h00;
      evIf.ev_ready = 1'b1;
      modelReset();
      #1 rst_n = 1'b0;
      #1 checkAllZero();
      @(posedge clk);
      #2 rst_n = 1'b1;

      $display("[TB] free-running increment");
      v = 0;
      for (int i = 0; i < 600; i++) begin
         applyStimulus(v, 1, 1, 0, 1);
         v = (v + 1) % 256;
      end
      checkOutput("run_wrap_cnt", int'(wrapCnt), 2);
      checkOutput("run_err", int'(err), 0);

      $display("[TB] single jump");
      applyStimulus(8'h0E, 1, 1, 0, 1);
      applyStimulus(8'h0F, 1, 1, 0, 1);
      applyStimulus(8'h10, 1, 1, 1, 1);
      applyStimulus(8'h14, 1, 1, 0, 1);
      applyStimulus(8'h15, 1, 1, 0, 1);
      applyStimulus(8'h16, 1, 1, 0, 1);
      checkOutput("jump_err_cnt", int'(errCnt), 1);

      $display("[TB] overflow with ready low");
      v = 8'h17;
      applyStimulus(v, 1, 1, 1, 0);
      for (int i = 0; i < 6; i++) begin
         v = (v + 3) % 256;
         applyStimulus(v, 1, 1, 0, 0);
         v = (v + 1) % 256;
         applyStimulus(v, 1, 1, 0, 0);
      end
      checkOutput("ovf_err_cnt", int'(errCnt), 6);
      checkOutput("ovf_flag", int'(evOvf), 1);
      for (int i = 0; i < 6; i++) begin
         v = (v + 1) % 256;
         applyStimulus(v, 1, 1, 0, 1);
      end
      checkOutput("drain_ev_valid", int'(evIf.ev_valid), 0);

      $display("[TB] decrement wrap and hold");
      applyStimulus(8'h03, 1, 0, 0, 1);
      applyStimulus(8'h02, 1, 0, 1, 1);
      applyStimulus(8'h01, 1, 0, 0, 1);
      applyStimulus(8'h00, 1, 0, 0, 1);
      applyStimulus(8'hFF, 1, 0, 0, 1);
      applyStimulus(8'hFE, 1, 0, 0, 1);
      checkOutput("dec_wrap_cnt", int'(wrapCnt), 1);
      checkOutput("dec_err", int'(err), 0);
      applyStimulus(8'hFE, 1, 0, 0, 1);
      applyStimulus(8'hFD, 1, 0, 0, 1);

      $display("[TB] clear coincident with mismatch");
      applyStimulus(8'h50, 1, 0, 1, 1);
      checkOutput("clr_err_cnt", int'(errCnt), 0);
      checkOutput("clr_locked", int'(locked), 1);
      checkOutput("clr_ev_valid", int'(evIf.ev_valid), 0);

      $display("[TB] randomised traffic");
      v   = 8'h4F;
      inc = 1'b0;
      e   = 1'b1;
      for (int i = 0; i < 2000; i++) begin
         if ($urandom_range(63) == 0) inc = ~inc;
         e = ($urandom_range(49) != 0);
         r = $urandom_range(99);
         if (r < 85)      v = inc ? (v + 1) % 256 : (v + 255) % 256;
         else if (r < 95) v = $urandom_range(255);
         applyStimulus(v, e, inc, ($urandom_range(99) == 0), $urandom_range(1) == 1);
      end

      $display("[TB] reset mid-track with events queued");
      v = 8'h30;
      for (int i = 0; i < 4; i++) begin
         v = (v + 1) % 256;
         applyStimulus(v, 1, 1, 0, 0);
      end
      for (int i = 0; i < 3; i++) begin
         v = (v + 5) % 256;
         applyStimulus(v, 1, 1, 0, 0);
      end
      checkOutput("pre_rst_ev_valid", int'(evIf.ev_valid), 1);
      rst_n = 1'b0;
      en    = 1'b0;
      #1 checkAllZero();
      modelReset();
      #1 rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         v = (v + 1) % 256;
         applyStimulus(v, 1, 1, 0, 1);
      end
      checkOutput("post_rst_err", int'(err), 0);
      checkOutput("post_rst_locked", int'(locked), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule

// File: doc/cnt_checker.md
# cnt_checker

Stream checker sitting directly downstream of the 8-bit `counter`. It samples `cnt` every clock and verifies that each value is the previous one ±1 modulo 2^W, in the direction set by `inc_dec`. It also keeps saturating error and wrap statistics. Every mismatch is queued as an {expected, got} event on a valid/ready port, so a bench or debug logger can drain mismatches at its own pace.

## Interface
- `W`, 8: counter width; must match the upstream counter.
- `inc_dec`, 1: expected direction; 1 = increment, 0 = decrement.
- `STAT_W`, 16: width of `err_cnt` and `wrap_cnt`.
- `DEPTH`, 4: event FIFO depth; power of two, ≥ 2.
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `cnt`  in  W: counter value under check.
- `en`  in  1: checking enable.
- `clr`  in  1: synchronous clear of statistics and FIFO.
- `locked`  out  1: a reference value is held and checking is active.
- `err`  out  1: sticky flag, set on the first mismatch.
- `err_cnt`  out  STAT_W: saturating mismatch count.
- `wrap_cnt`  out  STAT_W: saturating count of legal wraps.
- `ev_valid`  out  1: event FIFO is non-empty.
- `ev_ready`  in  1: consumer accepts the head event.
- `ev_exp`  out  W: expected value of the head event.
- `ev_got`  out  W: observed value of the head event.
- `ev_ovf`  out  1: sticky flag, set when an event was dropped because the FIFO was full.

## Operation
- FSM states: IDLE, SYNC, TRACK.
  - IDLE → SYNC when `en`=1.
  - SYNC: capture `cnt` into `prev`, then → TRACK.
  - TRACK: check every cycle.
  - Any state → IDLE when `en`=0. `prev` becomes invalid; statistics and FIFO are retained.
- Expected value `exp` = `prev`+1 if `inc_dec`=1, else `prev`−1, truncated to W bits.
- TRACK, `cnt`==`exp`:
  - `prev` ← `cnt`.
  - Legal wrap (FF→00 for increment, 00→FF for decrement) increments `wrap_cnt`, saturating at all-ones.
- TRACK, `cnt`≠`exp`:
  - This includes a held value.
  - `err` ← 1; `err_cnt` increments, saturating.
  - {`exp`, `cnt`} is pushed to the FIFO. If the FIFO is full and not popping this cycle, the event is dropped and `ev_ovf` ← 1.
  - `prev` ← `cnt`: the checker resyncs, so one jump produces exactly one error.
- `clr`=1: `err`, `err_cnt`, `wrap_cnt` and `ev_ovf` go to 0 and the FIFO is flushed.
  - `clr` has priority over any same-cycle update or push.
  - FSM state and `prev` are unaffected.
- FIFO:
  - Pop happens when `ev_valid` && `ev_ready`.
  - Push and pop in the same cycle are both accepted, including when full.
  - `ev_exp`/`ev_got` stay stable while `ev_valid` && !`ev_ready`.
- Reset, asynchronous and allowed mid-operation:
  - FSM goes to IDLE.
  - All outputs go to 0: `locked`, `err`, `err_cnt`, `wrap_cnt`, `ev_valid`, `ev_exp`, `ev_got`, `ev_ovf`.
  - FIFO is emptied.

## Timing
- All outputs are registered.
- `locked`:
  - Rises on the edge leaving SYNC, so it is high 2 cycles after `en` rises from IDLE.
  - Falls on the first edge at which `en`=0 is sampled.
- The first value checked is the one sampled on the edge after the SYNC capture.
- A mismatch sampled at edge N appears at edge N, i.e. visible in cycle N+1:
  - `err`/`err_cnt` updated.
  - `ev_valid`=1 if the FIFO was empty.
- Wrap accounting is visible one cycle after the wrap sample.
- FIFO latency is 1 cycle, push to `ev_valid`. There is no fall-through.

## Structure
- Package `cnt_checker_pkg` holds:
  - the state enum typedef (IDLE/SYNC/TRACK);
  - a packed struct typedef `cnt_ev_t` {exp, got}, parameterised by W through a package parameter default of 8;
  - a function `next_exp(prev, inc_dec)`.
- Sub-module `cnt_ev_fifo`: a synchronous FIFO of `cnt_ev_t`, DEPTH entries, with push/pop/full/empty/flush.
- The FSM, compare and statistics logic stay in `cnt_checker`.

## Test plan
- Reset, `en`=1, connect `counter` with `inc_dec`=1 and run 600 cycles → `locked`=1 from cycle 2, `err`=0, `wrap_cnt`=2, `ev_valid` never asserts.
- Force `cnt` 0x10→0x14→0x15 → `err_cnt`=1, one event {exp 0x11, got 0x14}, no further errors.
- Hold `ev_ready`=0 and inject 6 single jumps with DEPTH=4 → 4 events queued in order, `ev_ovf`=1, `err_cnt`=6. Then `ev_ready`=1 → 4 pops, after which `ev_valid`=0.
- `inc_dec`=0, count 0x01→0x00→0xFF→0xFE → `wrap_cnt`=1, `err`=0. Holding at 0xFE for one cycle → event {0xFD, 0xFE}.
- `clr` on the same cycle as a mismatch → stats stay 0, FIFO empty, `locked` still 1.
- Pulse `rst_n` low mid-TRACK with events queued → all outputs 0 immediately. After reset, `en`=1 resyncs with no error.
